// File: rtl/seg_display_scanner.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
// Each digit slot is followed by an all-off guard interval; new data lands only at frame boundaries.
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              digit_nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    pending
);

  // state    | meaning
  // ST_IDLE  | display off, waiting for enable
  // ST_DRIVE | digit idx lit with its shadow nibble for REFRESH_DIV cycles
  // ST_GUARD | all digits off for GUARD_CYCLES cycles before the next digit
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GUARD} state_t;

  localparam int MAXC = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int GT   = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GT);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [CW-1:0]           r_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_blank;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pending;
  logic [3:0]              r_nibble;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_frame_done;

  state_t                  w_state;
  logic [IW-1:0]           w_idx;
  logic [CW-1:0]           w_cnt;
  logic [4*NUM_DIGITS-1:0] w_shadow;
  logic [NUM_DIGITS-1:0]   w_shadow_blank;
  logic [4*NUM_DIGITS-1:0] w_pend_val;
  logic [NUM_DIGITS-1:0]   w_pend_blank;
  logic                    w_pending;
  logic                    w_boundary;
  logic                    w_adv;
  logic                    w_frame_done;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_sel;

  always_comb begin
    w_state        = r_state;
    w_idx          = r_idx;
    w_cnt          = r_cnt;
    w_shadow       = r_shadow;
    w_shadow_blank = r_shadow_blank;
    w_pend_val     = r_pend_val;
    w_pend_blank   = r_pend_blank;
    w_pending      = r_pending;
    w_boundary     = 1'b0;
    w_adv          = 1'b0;
    w_frame_done   = 1'b0;
    w_nibble       = 4'h0;
    w_sel          = '1;

    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state    = ST_DRIVE;
          w_idx      = '0;
          w_cnt      = '0;
          w_boundary = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          w_state = ST_IDLE;
          w_idx   = '0;
          w_cnt   = '0;
        end else if (r_cnt == DRIVE_LAST) begin
          w_cnt = '0;
          if (GUARD_CYCLES == 0) w_adv = 1'b1;
          else                   w_state = ST_GUARD;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      ST_GUARD: begin
        if (!enable) begin
          w_state = ST_IDLE;
          w_idx   = '0;
          w_cnt   = '0;
        end else if (r_cnt == GUARD_LAST) begin
          w_cnt = '0;
          w_adv = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_idx   = '0;
        w_cnt   = '0;
      end
    endcase

    if (w_adv) begin
      w_state = ST_DRIVE;
      if (r_idx == IDX_LAST) begin
        w_idx        = '0;
        w_frame_done = 1'b1;
        w_boundary   = 1'b1;
      end else begin
        w_idx = r_idx + IW'(1);
      end
    end

    // A load coinciding with a boundary bypasses the pending stage entirely.
    if (load) begin
      if (w_boundary) begin
        w_shadow       = value_in;
        w_shadow_blank = blank_in;
        w_pending      = 1'b0;
      end else begin
        w_pend_val   = value_in;
        w_pend_blank = blank_in;
        w_pending    = 1'b1;
      end
    end else if (w_boundary && r_pending) begin
      w_shadow       = r_pend_val;
      w_shadow_blank = r_pend_blank;
      w_pending      = 1'b0;
    end

    // Outputs are derived from next-state values so they line up with the state register.
    if (w_state == ST_DRIVE) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (w_idx == IW'(d)) begin
          w_nibble = w_shadow[4*d +: 4];
          w_sel[d] = w_shadow_blank[d];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_shadow       <= '0;
      r_shadow_blank <= '1;
      r_pend_val     <= '0;
      r_pend_blank   <= '1;
      r_pending      <= 1'b0;
      r_nibble       <= 4'h0;
      r_sel          <= '1;
      r_frame_done   <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_idx          <= w_idx;
      r_cnt          <= w_cnt;
      r_shadow       <= w_shadow;
      r_shadow_blank <= w_shadow_blank;
      r_pend_val     <= w_pend_val;
      r_pend_blank   <= w_pend_blank;
      r_pending      <= w_pending;
      r_nibble       <= w_nibble;
      r_sel          <= w_sel;
      r_frame_done   <= w_frame_done;
    end
  end

  assign digit_nibble = r_nibble;
  assign digit_sel    = r_sel;
  assign frame_done   = r_frame_done;
  assign pending      = r_pending;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
// Each digit slot is 5 cycles: 4 driven, 1 guard; a frame is 20 cycles.
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  blank_in;
  logic [3:0]  digit_nibble;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        pending;

  int total = 0;
  int bad   = 0;

  seg_display_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .value_in    (value_in),
    .blank_in    (blank_in),
    .digit_nibble(digit_nibble),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] esel, input logic [3:0] enib,
                         input logic efd, input logic epend);
    chk({tag, ".sel"}, 32'(digit_sel), 32'(esel));
    chk({tag, ".nib"}, 32'(digit_nibble), 32'(enib));
    chk({tag, ".fd"},  32'(frame_done), 32'(efd));
    chk({tag, ".pend"}, 32'(pending), 32'(epend));
  endtask

  // One 5-cycle digit slot; optionally strobes load after checking cycle ld_at.
  task automatic slot(input string tag, input logic [3:0] esel, input logic [3:0] enib,
                      input logic efd, input logic epend, input int ld_at,
                      input logic [15:0] ld_v, input logic [3:0] ld_b);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) begin
        chk({tag, ".sel"}, 32'(digit_sel), 32'(esel));
        chk({tag, ".nib"}, 32'(digit_nibble), 32'(enib));
      end else begin
        chk({tag, ".gsel"}, 32'(digit_sel), 32'hF);
        chk({tag, ".gnib"}, 32'(digit_nibble), 32'h0);
      end
      chk({tag, ".fd"}, 32'(frame_done), (k == 0) ? 32'(efd) : 32'h0);
      if (k == 0) chk({tag, ".pend"}, 32'(pending), 32'(epend));
      load = 1'b0;
      if (k == ld_at) begin
        load     = 1'b1;
        value_in = ld_v;
        blank_in = ld_b;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    value_in = 16'h0;
    blank_in = 4'h0;
    tick();
    tick();
    chk_all("rst", 4'hF, 4'h0, 1'b0, 1'b0);

    // 1: load at IDLE->DRIVE goes straight to shadow
    reset    = 1'b0;
    enable   = 1'b1;
    load     = 1'b1;
    value_in = 16'h3A7F;
    blank_in = 4'h0;
    slot("f1d0", 4'hE, 4'hF, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f1d1", 4'hD, 4'h7, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f1d2", 4'hB, 4'hA, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f1d3", 4'h7, 4'h3, 1'b0, 1'b0, -1, 16'h0, 4'h0);

    // 2: mid-frame load stays pending until the wrap
    slot("f2d0", 4'hE, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f2d1", 4'hD, 4'h7, 1'b0, 1'b0, 1, 16'h1234, 4'h0);
    slot("f2d2", 4'hB, 4'hA, 1'b0, 1'b1, -1, 16'h0, 4'h0);
    slot("f2d3", 4'h7, 4'h3, 1'b0, 1'b1, -1, 16'h0, 4'h0);

    // 3: two loads in one frame, last wins
    slot("f3d0", 4'hE, 4'h4, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f3d1", 4'hD, 4'h3, 1'b0, 1'b0, 0, 16'h1111, 4'h0);
    slot("f3d2", 4'hB, 4'h2, 1'b0, 1'b1, 0, 16'h2222, 4'h0);
    slot("f3d3", 4'h7, 4'h1, 1'b0, 1'b1, -1, 16'h0, 4'h0);

    // 4: load in the exact wrap cycle
    slot("f4d0", 4'hE, 4'h2, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f4d1", 4'hD, 4'h2, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f4d2", 4'hB, 4'h2, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f4d3", 4'h7, 4'h2, 1'b0, 1'b0, 4, 16'h5555, 4'h0);
    slot("f5d0", 4'hE, 4'h5, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f5d1", 4'hD, 4'h5, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f5d2", 4'hB, 4'h5, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f5d3", 4'h7, 4'h5, 1'b0, 1'b0, 4, 16'h9876, 4'b1010);

    // 5: blanked digits 1 and 3 stay dark, timing unchanged
    slot("f6d0", 4'hE, 4'h6, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f6d1", 4'hF, 4'h7, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f6d2", 4'hB, 4'h8, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    slot("f6d3", 4'hF, 4'h9, 1'b0, 1'b0, -1, 16'h0, 4'h0);

    // 6: enable drop mid-DRIVE keeps pending; reset in GUARD restores reset values
    tick();
    chk_all("f7c0", 4'hE, 4'h6, 1'b1, 1'b0);
    load     = 1'b1;
    value_in = 16'hBEEF;
    blank_in = 4'h0;
    tick();
    chk_all("f7c1", 4'hE, 4'h6, 1'b0, 1'b1);
    load   = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("off", 4'hF, 4'h0, 1'b0, 1'b1);
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("reen", 4'hE, 4'hF, 1'b0, 1'b0);
    end
    tick();
    chk_all("reguard", 4'hF, 4'h0, 1'b0, 1'b0);
    reset    = 1'b1;
    load     = 1'b1;
    value_in = 16'h1234;
    tick();
    chk_all("rst2a", 4'hF, 4'h0, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    chk_all("rst2b", 4'hF, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("post", 4'hF, 4'h0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
